// File: rtl/tlb_unit_pkg.sv
// Shared definitions for the joint TLB: op and strobe encodings, FSM states,
// CP0 register field positions and the stored entry layout.
package tlb_defs_pkg;

    localparam int TLB_NUM_DEF   = 16;
    localparam int TLB_IDX_W_DEF = 4;

    typedef enum logic [1:0] {
        TLB_OP_TLBWR = 2'b00,
        TLB_OP_TLBR  = 2'b01,
        TLB_OP_TLBP  = 2'b10,
        TLB_OP_TLBWI = 2'b11
    } tlb_op_e;

    localparam logic [1:0] TLBM_NONE = 2'b00;
    localparam logic [1:0] TLBM_TLBR = 2'b01;
    localparam logic [1:0] TLBM_TLBP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } tlb_state_e;

    localparam int EHI_VPN2_MSB = 31;
    localparam int EHI_VPN2_LSB = 13;
    localparam int EHI_ASID_MSB = 7;
    localparam int PM_MASK_MSB  = 24;
    localparam int PM_MASK_LSB  = 13;
    localparam int LO_PFN_MSB   = 25;
    localparam int LO_PFN_LSB   = 6;
    localparam int LO_C_MSB     = 5;
    localparam int LO_C_LSB     = 3;
    localparam int LO_D_BIT     = 2;
    localparam int LO_V_BIT     = 1;
    localparam int LO_G_BIT     = 0;

    localparam logic [31:0] TLBP_MISS = 32'h8000_0000;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_half_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [11:0] mask;
        logic        g;
        tlb_half_t   lo0;
        tlb_half_t   lo1;
    } tlb_entry_t;

    // Rebuild an EntryLo word; G is the shared entry bit, replicated into both halves.
    function automatic logic [31:0] half_to_lo(input tlb_half_t h, input logic g);
        return {6'b0, h.pfn, h.c, h.d, h.v, g};
    endfunction

endpackage

// File: rtl/tlb_unit_if.sv
// CP0-side TLB instruction channel: request, CP0 operand words and result words.
interface tlb_unit_if;
    logic        op_valid_i;
    logic [1:0]  op_i;
    logic        op_ready_o;
    logic        flushM;
    logic        stallM;
    logic [31:0] CP0_INDEX;
    logic [31:0] CP0_ENTRYHI;
    logic [31:0] CP0_ENTRYLO0;
    logic [31:0] CP0_ENTRYLO1;
    logic [31:0] CP0_PAGEMASK;
    logic [31:0] Index_out;
    logic [31:0] PageMask_out;
    logic [31:0] EntryLo0_out;
    logic [31:0] EntryLo1_out;
    logic [31:0] EntryHi_out;
    logic [1:0]  tlbM_type;
    logic        op_done_o;

    modport master (
        output op_valid_i, op_i, flushM, stallM,
               CP0_INDEX, CP0_ENTRYHI, CP0_ENTRYLO0, CP0_ENTRYLO1, CP0_PAGEMASK,
        input  op_ready_o, Index_out, PageMask_out, EntryLo0_out, EntryLo1_out,
               EntryHi_out, tlbM_type, op_done_o
    );

    modport slave (
        input  op_valid_i, op_i, flushM, stallM,
               CP0_INDEX, CP0_ENTRYHI, CP0_ENTRYLO0, CP0_ENTRYLO1, CP0_PAGEMASK,
        output op_ready_o, Index_out, PageMask_out, EntryLo0_out, EntryLo1_out,
               EntryHi_out, tlbM_type, op_done_o
    );
endinterface

// File: rtl/tlb_unit_match.sv
// Parallel VPN2/ASID compare against every TLB entry; reports a hit and the
// lowest matching index.
module tlb_match
    import tlb_defs_pkg::*;
#(
    parameter int N  = TLB_NUM_DEF,
    parameter int IW = TLB_IDX_W_DEF
) (
    input  logic [N-1:0][18:0] vpn2_a,
    input  logic [N-1:0][7:0]  asid_a,
    input  logic [N-1:0][11:0] mask_a,
    input  logic [N-1:0]       g_a,
    input  logic [18:0]        vpn2_i,
    input  logic [7:0]         asid_i,
    output logic               hit_o,
    output logic [IW-1:0]      idx_o
);

    logic [N-1:0] match;

    // MASK lines up with the low VPN2 bits, so it is zero-extended at the top.
    for (genvar gi = 0; gi < N; gi++) begin : g_cmp
        assign match[gi] = (((vpn2_a[gi] ^ vpn2_i) & ~{7'b0, mask_a[gi]}) == 19'b0) &&
                           (g_a[gi] || (asid_a[gi] == asid_i));
    end

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_unit.sv
// Joint TLB: TLBR/TLBP/TLBWI sequencer plus instruction and data translation.
// Optional TLBWR with a Random counter when TLB_TLBWR_EN is defined.
module tlb_unit
    import tlb_defs_pkg::*;
#(
    parameter int TLB_NUM = TLB_NUM_DEF,
    parameter int IDX_W   = TLB_IDX_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    tlb_unit_if.slave   op_if,
    input  logic [31:0] inst_vaddr_i,
    input  logic [31:0] data_vaddr_i,
    input  logic        data_we_i,
    output logic [31:0] inst_paddr_o,
    output logic [31:0] data_paddr_o,
    output logic        inst_refill_o,
    output logic        inst_invalid_o,
    output logic        data_refill_o,
    output logic        data_invalid_o,
    output logic        data_modified_o
);

    tlb_entry_t         tlb_q [TLB_NUM];
    tlb_state_e         state_q, state_d;
    tlb_op_e            op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    tlb_entry_t         wentry_q, wentry_d;
    logic [1:0]         tlbm_type_q, tlbm_type_d;
    logic               op_done_q, op_done_d;
    logic               op_ready_q, op_ready_d;
    logic [31:0]        index_out_q, index_out_d;
    logic [31:0]        pagemask_out_q, pagemask_out_d;
    logic [31:0]        lo0_out_q, lo0_out_d;
    logic [31:0]        lo1_out_q, lo1_out_d;
    logic [31:0]        ehi_out_q, ehi_out_d;
    logic               wr_en;
    logic               op_legal;
    logic               accept;
    tlb_entry_t         cp0_entry;
    tlb_entry_t         rd_entry;

    logic [TLB_NUM-1:0][18:0] key_vpn2;
    logic [TLB_NUM-1:0][7:0]  key_asid;
    logic [TLB_NUM-1:0][11:0] key_mask;
    logic [TLB_NUM-1:0]       key_g;

    for (genvar gi = 0; gi < TLB_NUM; gi++) begin : g_keys
        assign key_vpn2[gi] = tlb_q[gi].vpn2;
        assign key_asid[gi] = tlb_q[gi].asid;
        assign key_mask[gi] = tlb_q[gi].mask;
        assign key_g[gi]    = tlb_q[gi].g;
    end

    always_comb begin
        cp0_entry         = '0;
        cp0_entry.vpn2    = op_if.CP0_ENTRYHI[EHI_VPN2_MSB:EHI_VPN2_LSB];
        cp0_entry.asid    = op_if.CP0_ENTRYHI[EHI_ASID_MSB:0];
        cp0_entry.mask    = op_if.CP0_PAGEMASK[PM_MASK_MSB:PM_MASK_LSB];
        cp0_entry.g       = op_if.CP0_ENTRYLO0[LO_G_BIT] & op_if.CP0_ENTRYLO1[LO_G_BIT];
        cp0_entry.lo0.pfn = op_if.CP0_ENTRYLO0[LO_PFN_MSB:LO_PFN_LSB];
        cp0_entry.lo0.c   = op_if.CP0_ENTRYLO0[LO_C_MSB:LO_C_LSB];
        cp0_entry.lo0.d   = op_if.CP0_ENTRYLO0[LO_D_BIT];
        cp0_entry.lo0.v   = op_if.CP0_ENTRYLO0[LO_V_BIT];
        cp0_entry.lo1.pfn = op_if.CP0_ENTRYLO1[LO_PFN_MSB:LO_PFN_LSB];
        cp0_entry.lo1.c   = op_if.CP0_ENTRYLO1[LO_C_MSB:LO_C_LSB];
        cp0_entry.lo1.d   = op_if.CP0_ENTRYLO1[LO_D_BIT];
        cp0_entry.lo1.v   = op_if.CP0_ENTRYLO1[LO_V_BIT];
    end

`ifdef TLB_TLBWR_EN
    logic [IDX_W-1:0] random_q, random_d;

    assign random_d = (random_q == '0) ? IDX_W'(TLB_NUM - 1) : random_q - 1'b1;
    assign op_legal = 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) random_q <= IDX_W'(TLB_NUM - 1);
        else      random_q <= random_d;
    end
`else
    assign op_legal = (op_if.op_i != TLB_OP_TLBWR);
`endif

    assign accept   = (state_q == ST_IDLE) && op_if.op_valid_i && op_legal &&
                      !op_if.stallM && !op_if.flushM;
    assign rd_entry = tlb_q[idx_q];

    logic             probe_hit;
    logic [IDX_W-1:0] probe_idx;

    tlb_match #(.N(TLB_NUM), .IW(IDX_W)) u_probe (
        .vpn2_a(key_vpn2), .asid_a(key_asid), .mask_a(key_mask), .g_a(key_g),
        .vpn2_i(wentry_q.vpn2), .asid_i(wentry_q.asid),
        .hit_o(probe_hit), .idx_o(probe_idx)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        idx_d          = idx_q;
        wentry_d       = wentry_q;
        tlbm_type_d    = TLBM_NONE;
        op_done_d      = 1'b0;
        index_out_d    = index_out_q;
        pagemask_out_d = pagemask_out_q;
        lo0_out_d      = lo0_out_q;
        lo1_out_d      = lo1_out_q;
        ehi_out_d      = ehi_out_q;
        wr_en          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_EXEC;
                    op_d     = tlb_op_e'(op_if.op_i);
                    wentry_d = cp0_entry;
                    idx_d    = op_if.CP0_INDEX[IDX_W-1:0];
`ifdef TLB_TLBWR_EN
                    if (op_if.op_i == TLB_OP_TLBWR) idx_d = random_q;
`endif
                end
            end
            ST_EXEC: begin
                // A flush wins over a stall: the op is dropped without touching the array.
                if (op_if.flushM) begin
                    state_d = ST_IDLE;
                end else if (!op_if.stallM) begin
                    state_d   = ST_RESP;
                    op_done_d = 1'b1;
                    case (op_q)
                        TLB_OP_TLBR: begin
                            tlbm_type_d    = TLBM_TLBR;
                            ehi_out_d      = {rd_entry.vpn2, 5'b0, rd_entry.asid};
                            pagemask_out_d = {7'b0, rd_entry.mask, 13'b0};
                            lo0_out_d      = half_to_lo(rd_entry.lo0, rd_entry.g);
                            lo1_out_d      = half_to_lo(rd_entry.lo1, rd_entry.g);
                        end
                        TLB_OP_TLBP: begin
                            tlbm_type_d = TLBM_TLBP;
                            index_out_d = probe_hit ? {1'b0, 31'(probe_idx)} : TLBP_MISS;
                        end
                        default: wr_en = 1'b1;
                    endcase
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        op_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            op_q           <= TLB_OP_TLBR;
            idx_q          <= '0;
            wentry_q       <= '0;
            tlbm_type_q    <= TLBM_NONE;
            op_done_q      <= 1'b0;
            op_ready_q     <= 1'b1;
            index_out_q    <= '0;
            pagemask_out_q <= '0;
            lo0_out_q      <= '0;
            lo1_out_q      <= '0;
            ehi_out_q      <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            idx_q          <= idx_d;
            wentry_q       <= wentry_d;
            tlbm_type_q    <= tlbm_type_d;
            op_done_q      <= op_done_d;
            op_ready_q     <= op_ready_d;
            index_out_q    <= index_out_d;
            pagemask_out_q <= pagemask_out_d;
            lo0_out_q      <= lo0_out_d;
            lo1_out_q      <= lo1_out_d;
            ehi_out_q      <= ehi_out_d;
        end
    end

    // The write lands on the EXEC->RESP edge, so a same-cycle lookup sees the old entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TLB_NUM; i++) tlb_q[i] <= '0;
        end else if (wr_en) begin
            tlb_q[idx_q] <= wentry_q;
        end
    end

    logic             inst_hit, data_hit;
    logic [IDX_W-1:0] inst_idx, data_idx;
    tlb_half_t        inst_half, data_half;
    logic [31:0]      inst_paddr_d, data_paddr_d;
    logic [31:0]      inst_paddr_q, data_paddr_q;
    logic             inst_refill_d, inst_invalid_d, data_refill_d, data_invalid_d, data_modified_d;
    logic             inst_refill_q, inst_invalid_q, data_refill_q, data_invalid_q, data_modified_q;

    tlb_match #(.N(TLB_NUM), .IW(IDX_W)) u_inst (
        .vpn2_a(key_vpn2), .asid_a(key_asid), .mask_a(key_mask), .g_a(key_g),
        .vpn2_i(inst_vaddr_i[31:13]), .asid_i(op_if.CP0_ENTRYHI[EHI_ASID_MSB:0]),
        .hit_o(inst_hit), .idx_o(inst_idx)
    );

    tlb_match #(.N(TLB_NUM), .IW(IDX_W)) u_data (
        .vpn2_a(key_vpn2), .asid_a(key_asid), .mask_a(key_mask), .g_a(key_g),
        .vpn2_i(data_vaddr_i[31:13]), .asid_i(op_if.CP0_ENTRYHI[EHI_ASID_MSB:0]),
        .hit_o(data_hit), .idx_o(data_idx)
    );

    always_comb begin
        inst_half      = inst_vaddr_i[12] ? tlb_q[inst_idx].lo1 : tlb_q[inst_idx].lo0;
        inst_paddr_d   = {3'b0, inst_vaddr_i[28:0]};
        inst_refill_d  = 1'b0;
        inst_invalid_d = 1'b0;
        if (inst_vaddr_i[31:30] != 2'b10) begin
            inst_paddr_d   = {inst_half.pfn, inst_vaddr_i[11:0]};
            inst_refill_d  = !inst_hit;
            inst_invalid_d = inst_hit && !inst_half.v;
        end
    end

    always_comb begin
        data_half       = data_vaddr_i[12] ? tlb_q[data_idx].lo1 : tlb_q[data_idx].lo0;
        data_paddr_d    = {3'b0, data_vaddr_i[28:0]};
        data_refill_d   = 1'b0;
        data_invalid_d  = 1'b0;
        data_modified_d = 1'b0;
        if (data_vaddr_i[31:30] != 2'b10) begin
            data_paddr_d    = {data_half.pfn, data_vaddr_i[11:0]};
            data_refill_d   = !data_hit;
            data_invalid_d  = data_hit && !data_half.v;
            data_modified_d = data_hit && data_half.v && !data_half.d && data_we_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_paddr_q    <= '0;
            data_paddr_q    <= '0;
            inst_refill_q   <= 1'b0;
            inst_invalid_q  <= 1'b0;
            data_refill_q   <= 1'b0;
            data_invalid_q  <= 1'b0;
            data_modified_q <= 1'b0;
        end else begin
            inst_paddr_q    <= inst_paddr_d;
            data_paddr_q    <= data_paddr_d;
            inst_refill_q   <= inst_refill_d;
            inst_invalid_q  <= inst_invalid_d;
            data_refill_q   <= data_refill_d;
            data_invalid_q  <= data_invalid_d;
            data_modified_q <= data_modified_d;
        end
    end

    assign op_if.op_ready_o   = op_ready_q;
    assign op_if.op_done_o    = op_done_q;
    assign op_if.tlbM_type    = tlbm_type_q;
    assign op_if.Index_out    = index_out_q;
    assign op_if.PageMask_out = pagemask_out_q;
    assign op_if.EntryLo0_out = lo0_out_q;
    assign op_if.EntryLo1_out = lo1_out_q;
    assign op_if.EntryHi_out  = ehi_out_q;

    assign inst_paddr_o    = inst_paddr_q;
    assign data_paddr_o    = data_paddr_q;
    assign inst_refill_o   = inst_refill_q;
    assign inst_invalid_o  = inst_invalid_q;
    assign data_refill_o   = data_refill_q;
    assign data_invalid_o  = data_invalid_q;
    assign data_modified_o = data_modified_q;

    logic unused_bits;
    assign unused_bits = ^{op_if.CP0_INDEX[31:IDX_W],
                           op_if.CP0_ENTRYHI[EHI_VPN2_LSB-1:EHI_ASID_MSB+1],
                           op_if.CP0_PAGEMASK[31:PM_MASK_MSB+1],
                           op_if.CP0_PAGEMASK[PM_MASK_LSB-1:0],
                           op_if.CP0_ENTRYLO0[31:LO_PFN_MSB+1],
                           op_if.CP0_ENTRYLO1[31:LO_PFN_MSB+1],
                           inst_half.c, inst_half.d, data_half.c};

endmodule

// File: tb/tb_tlb_unit.sv
// Directed bench for tlb_unit: CP0 TLB ops, flush/stall/reset handling and
// instruction/data translation against hand-computed values.
module tb_tlb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_vaddr, data_vaddr, inst_paddr, data_paddr;
    logic        data_we;
    logic        inst_refill, inst_invalid, data_refill, data_invalid, data_modified;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    tlb_unit_if op_if();

    tlb_unit dut (
        .clk(clk), .rst(rst), .op_if(op_if),
        .inst_vaddr_i(inst_vaddr), .data_vaddr_i(data_vaddr), .data_we_i(data_we),
        .inst_paddr_o(inst_paddr), .data_paddr_o(data_paddr),
        .inst_refill_o(inst_refill), .inst_invalid_o(inst_invalid),
        .data_refill_o(data_refill), .data_invalid_o(data_invalid),
        .data_modified_o(data_modified)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cp0(input logic [31:0] index, ehi, lo0, lo1, pm);
        op_if.CP0_INDEX    = index;
        op_if.CP0_ENTRYHI  = ehi;
        op_if.CP0_ENTRYLO0 = lo0;
        op_if.CP0_ENTRYLO1 = lo1;
        op_if.CP0_PAGEMASK = pm;
    endtask

    // Issue one op; checks accept-to-strobe latency, strobe type and one-cycle pulse.
    task automatic do_op(input logic [1:0] op, input logic [31:0] index, ehi, lo0, lo1, pm,
                         input int stall, input logic [1:0] exp_type);
        int cyc;
        check("ready_before_op", op_if.op_ready_o, 1);
        set_cp0(index, ehi, lo0, lo1, pm);
        op_if.op_i       = op;
        op_if.op_valid_i = 1'b1;
        tick();
        op_if.op_valid_i = 1'b0;
        op_if.stallM     = (stall > 0);
        cyc = 0;
        while (cyc < 8) begin
            tick();
            cyc++;
            if (cyc == stall) op_if.stallM = 1'b0;
            if (op_if.op_done_o) break;
        end
        op_if.stallM = 1'b0;
        $display("op=%0d idx=%0d ehi=%h stall=%0d cycles=%0d type=%0d index_out=%h",
                 op, index, ehi, stall, cyc, op_if.tlbM_type, op_if.Index_out);
        check("op_latency", cyc, 1 + stall);
        check("op_type", op_if.tlbM_type, exp_type);
        tick();
        check("done_one_cycle", op_if.op_done_o, 0);
        check("type_one_cycle", op_if.tlbM_type, 0);
    endtask

    task automatic lookup(input logic [31:0] iva, dva, input logic we);
        inst_vaddr = iva;
        data_vaddr = dva;
        data_we    = we;
        tick();
        $display("lookup iva=%h ipa=%h iref=%0d dva=%h we=%0d dpa=%h dref=%0d dinv=%0d dmod=%0d",
                 iva, inst_paddr, inst_refill, dva, we, data_paddr, data_refill,
                 data_invalid, data_modified);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%h exp=%h", 32'd1, 32'd0);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        op_if.op_valid_i = 1'b0;
        op_if.op_i       = 2'b00;
        op_if.flushM     = 1'b0;
        op_if.stallM     = 1'b0;
        set_cp0(0, 0, 0, 0, 0);
        inst_vaddr = '0;
        data_vaddr = '0;
        data_we    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", op_if.op_ready_o, 1);
        check("rst_type", op_if.tlbM_type, 0);
        check("rst_done", op_if.op_done_o, 0);
        check("rst_index", op_if.Index_out, 0);
        check("rst_ehi", op_if.EntryHi_out, 0);
        check("rst_dpaddr", data_paddr, 0);
        check("rst_drefill", data_refill, 0);
        check("rst_irefill", inst_refill, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Unmapped kseg1 fetch with empty TLB; mapped data access refills.
        lookup(32'hBFC0_0000, 32'h0040_2123, 1'b0);
        check("kseg1_ipaddr", inst_paddr, 32'h1FC0_0000);
        check("kseg1_irefill", inst_refill, 0);
        check("empty_drefill", data_refill, 1);

        // Entry 3: VPN2 0x201 ASID 5, even PFN 2 D=0 V=1, odd PFN 2 D=1 V=1, G=0.
        do_op(2'b11, 3, 32'h0040_2005, 32'h0000_0082, 32'h0000_0087, 0, 0, 2'b00);
        do_op(2'b01, 3, 32'h0040_2005, 0, 0, 0, 0, 2'b01);
        check("tlbr3_ehi", op_if.EntryHi_out, 32'h0040_2005);
        check("tlbr3_lo0", op_if.EntryLo0_out, 32'h0000_0082);
        check("tlbr3_lo1", op_if.EntryLo1_out, 32'h0000_0086);
        check("tlbr3_pm", op_if.PageMask_out, 0);

        do_op(2'b10, 0, 32'h0040_2005, 0, 0, 0, 0, 2'b10);
        check("tlbp_hit", op_if.Index_out, 32'h0000_0003);
        do_op(2'b10, 0, 32'h0040_2006, 0, 0, 0, 2, 2'b10);
        check("tlbp_asid_miss", op_if.Index_out, 32'h8000_0000);

        op_if.CP0_ENTRYHI = 32'h0040_2005;
        lookup(32'h0, 32'h0040_2123, 1'b0);
        check("load_paddr", data_paddr, 32'h0000_2123);
        check("load_refill", data_refill, 0);
        check("load_invalid", data_invalid, 0);
        check("load_modified", data_modified, 0);
        lookup(32'h0, 32'h0040_2123, 1'b1);
        check("store_clean_mod", data_modified, 1);
        lookup(32'h0, 32'h0040_3000, 1'b1);
        check("odd_paddr", data_paddr, 32'h0000_2000);
        check("odd_invalid", data_invalid, 0);
        check("odd_store_mod", data_modified, 0);
        lookup(32'h0, 32'h1000_0000, 1'b0);
        check("unmapped_refill", data_refill, 1);
        lookup(32'h0, 32'h8000_1234, 1'b0);
        check("kseg0_dpaddr", data_paddr, 32'h0000_1234);
        check("kseg0_drefill", data_refill, 0);
        op_if.CP0_ENTRYHI = 32'h0040_2006;
        lookup(32'h0, 32'h0040_2123, 1'b0);
        check("asid_refill", data_refill, 1);
        op_if.CP0_ENTRYHI = 32'h0040_2005;

        // Entry 1: even half invalid.
        do_op(2'b11, 1, 32'h0080_0005, 32'h0000_0100, 32'h0, 0, 0, 2'b00);
        lookup(32'h0, 32'h0080_0010, 1'b0);
        check("inv_invalid", data_invalid, 1);
        check("inv_refill", data_refill, 0);
        check("inv_paddr", data_paddr, 32'h0000_4010);

        // Entry 9: PageMask masks the two low VPN2 bits.
        do_op(2'b11, 9, 32'h0100_0005, 32'h0000_0302, 32'h0000_0342, 32'h0000_6000, 0, 2'b00);
        lookup(32'h0, 32'h0100_6000, 1'b0);
        check("mask_paddr", data_paddr, 32'h0000_C000);
        check("mask_refill", data_refill, 0);
        lookup(32'h0, 32'h0100_8000, 1'b0);
        check("mask_out_refill", data_refill, 1);
        do_op(2'b01, 9, 32'h0040_2005, 0, 0, 0, 0, 2'b01);
        check("tlbr9_pm", op_if.PageMask_out, 32'h0000_6000);
        check("tlbr9_ehi", op_if.EntryHi_out, 32'h0100_0005);
        check("tlbr9_lo0", op_if.EntryLo0_out, 32'h0000_0302);
        check("tlbr9_lo1", op_if.EntryLo1_out, 32'h0000_0342);

        // Entry 7 duplicates entry 3: lowest index must win.
        do_op(2'b11, 7, 32'h0040_2005, 32'h0000_0142, 32'h0, 0, 0, 2'b00);
        do_op(2'b10, 0, 32'h0040_2005, 0, 0, 0, 0, 2'b10);
        check("tlbp_lowest", op_if.Index_out, 32'h0000_0003);
        lookup(32'h0, 32'h0040_2123, 1'b0);
        check("lowest_paddr", data_paddr, 32'h0000_2123);

        // TLBWI to entry 5 flushed in EXEC.
        set_cp0(5, 32'h00A0_0005, 32'h0000_0047, 32'h0000_0047, 0);
        op_if.op_i       = 2'b11;
        op_if.op_valid_i = 1'b1;
        tick();
        op_if.op_valid_i = 1'b0;
        op_if.flushM     = 1'b1;
        tick();
        op_if.flushM = 1'b0;
        $display("flush op=3 idx=5 done=%0d ready=%0d", op_if.op_done_o, op_if.op_ready_o);
        check("flush_done", op_if.op_done_o, 0);
        check("flush_ready", op_if.op_ready_o, 1);
        tick();
        check("flush_done_late", op_if.op_done_o, 0);
        lookup(32'h0, 32'h00A0_0000, 1'b0);
        check("flush_refill", data_refill, 1);
        do_op(2'b01, 5, 32'h0040_2005, 0, 0, 0, 0, 2'b01);
        check("flush_tlbr_ehi", op_if.EntryHi_out, 0);
        check("flush_tlbr_lo0", op_if.EntryLo0_out, 0);
        check("flush_tlbr_lo1", op_if.EntryLo1_out, 0);

        // Reset asserted while a TLBWI sits in EXEC.
        set_cp0(2, 32'h0040_2005, 32'h0000_0082, 32'h0000_0082, 0);
        op_if.op_i       = 2'b11;
        op_if.op_valid_i = 1'b1;
        tick();
        op_if.op_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        $display("reset mid-op ready=%0d done=%0d", op_if.op_ready_o, op_if.op_done_o);
        check("midrst_ready", op_if.op_ready_o, 1);
        check("midrst_done", op_if.op_done_o, 0);
        @(negedge clk);
        rst = 1'b1;
        lookup(32'h0040_2000, 32'h0040_2123, 1'b0);
        check("midrst_irefill", inst_refill, 1);
        check("midrst_drefill", data_refill, 1);
        check("midrst_no_strobe", op_if.op_done_o, 0);
        check("midrst_no_type", op_if.tlbM_type, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
